// File: rtl/ex_muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit_if
// Pipeline-side bundle of the EX-stage RV32M multiply/divide unit.
//   flush_i  : kill any in-flight operation
//   start_i  : EX instruction is an M-extension op (accepted only when idle)
//   op_i     : funct3 of the M-extension instruction
//   rs1_i    : operand 1 (dividend / multiplicand)
//   rs2_i    : operand 2 (divisor / multiplier)
//   stall_o  : holds the pipeline while the unit computes
//   busy_o   : unit is not idle
//   done_o   : one-cycle completion strobe
//   result_o : 32-bit result, held between completions
// master = pipeline side, slave = the unit.
// ----------------------------------------------------------------------------
interface ex_muldiv_unit_if;
  logic        flush_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  modport master (
    output flush_i, start_i, op_i, rs1_i, rs2_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  flush_i, start_i, op_i, rs1_i, rs2_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ----------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative RV32M multiply/divide unit for the EX stage. One result bit per
// cycle (32 CALC cycles); divide-by-zero and signed overflow take a short
// FAST path. Operands are converted to magnitudes on accept and the sign is
// restored when the result is registered.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   mdu   : ex_muldiv_unit_if.slave (flush/start/op/operands in,
//           stall/busy/done/result out)
// ----------------------------------------------------------------------------
module ex_muldiv_unit (
  input  logic            clk_i,
  input  logic            rst_i,
  ex_muldiv_unit_if.slave mdu
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FAST = 2'd1,
    ST_CALC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e      state_r;
  logic [2:0]  op_r;
  logic        s1_r;
  logic        s2_r;
  logic [5:0]  cnt_r;
  // {hi, lo}: multiply = {partial product, remaining multiplier},
  // divide = {remainder, dividend/quotient}
  logic [63:0] acc_r;
  // multiplicand magnitude (multiply) or divisor magnitude (divide)
  logic [31:0] opb_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] result_r;

  logic        is_div_s;
  logic        sgn1_s;
  logic        sgn2_s;
  logic [31:0] mag1_s;
  logic [31:0] mag2_s;
  logic        div_zero_s;
  logic        div_ovf_s;
  logic        fast_s;
  logic [31:0] fast_res_s;

  logic [32:0] sum_s;
  logic [32:0] rem_sh_s;
  logic [32:0] diff_s;
  logic [63:0] acc_step_s;
  logic [63:0] prod_fix_s;
  logic [31:0] quo_fix_s;
  logic [31:0] rem_fix_s;
  logic [31:0] calc_res_s;

  // Two's-complement negate of a 32-bit value.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Decode the incoming op: operand signs, magnitudes and fast-path result.
  always_comb begin
    is_div_s   = mdu.op_i[2];
    sgn1_s     = 1'b0;
    sgn2_s     = 1'b0;
    case (mdu.op_i)
      3'b001, 3'b100, 3'b110: begin
        sgn1_s = mdu.rs1_i[31];
        sgn2_s = mdu.rs2_i[31];
      end
      3'b010: begin
        sgn1_s = mdu.rs1_i[31];
        sgn2_s = 1'b0;
      end
      default: begin
        sgn1_s = 1'b0;
        sgn2_s = 1'b0;
      end
    endcase
    mag1_s     = sgn1_s ? neg32(mdu.rs1_i) : mdu.rs1_i;
    mag2_s     = sgn2_s ? neg32(mdu.rs2_i) : mdu.rs2_i;
    div_zero_s = is_div_s && (mdu.rs2_i == 32'h0000_0000);
    div_ovf_s  = ((mdu.op_i == 3'b100) || (mdu.op_i == 3'b110)) &&
                 (mdu.rs1_i == 32'h8000_0000) && (mdu.rs2_i == 32'hFFFF_FFFF);
    fast_s     = div_zero_s || div_ovf_s;
    // op_i[1] selects remainder among the divide ops
    if (div_zero_s) begin
      fast_res_s = mdu.op_i[1] ? mdu.rs1_i : 32'hFFFF_FFFF;
    end else if (div_ovf_s) begin
      fast_res_s = mdu.op_i[1] ? 32'h0000_0000 : 32'h8000_0000;
    end else begin
      fast_res_s = 32'h0000_0000;
    end
  end

  // One iteration step and the sign-corrected result of the final step.
  always_comb begin
    sum_s    = {1'b0, acc_r[63:32]} + {1'b0, opb_r};
    rem_sh_s = acc_r[63:31];
    diff_s   = rem_sh_s - {1'b0, opb_r};
    if (op_r[2]) begin
      // restoring divide: keep the difference only when it did not borrow
      if (!diff_s[32]) begin
        acc_step_s = {diff_s[31:0], acc_r[30:0], 1'b1};
      end else begin
        acc_step_s = {rem_sh_s[31:0], acc_r[30:0], 1'b0};
      end
    end else begin
      // shift-add multiply, multiplier LSB first
      if (acc_r[0]) begin
        acc_step_s = {sum_s, acc_r[31:1]};
      end else begin
        acc_step_s = {1'b0, acc_r[63:1]};
      end
    end
    prod_fix_s = (s1_r ^ s2_r) ? (64'd0 - acc_step_s) : acc_step_s;
    quo_fix_s  = (s1_r ^ s2_r) ? neg32(acc_step_s[31:0]) : acc_step_s[31:0];
    rem_fix_s  = s1_r ? neg32(acc_step_s[63:32]) : acc_step_s[63:32];
    case (op_r)
      3'b000:                 calc_res_s = prod_fix_s[31:0];
      3'b001, 3'b010, 3'b011: calc_res_s = prod_fix_s[63:32];
      3'b100, 3'b101:         calc_res_s = quo_fix_s;
      3'b110, 3'b111:         calc_res_s = rem_fix_s;
      default:                calc_res_s = 32'h0000_0000;
    endcase
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      op_r     <= 3'd0;
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      cnt_r    <= 6'd0;
      acc_r    <= 64'd0;
      opb_r    <= 32'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 32'd0;
    end else if (mdu.flush_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mdu.start_i) begin
            op_r   <= mdu.op_i;
            s1_r   <= sgn1_s;
            s2_r   <= sgn2_s;
            cnt_r  <= 6'd0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
            if (fast_s) begin
              state_r <= ST_FAST;
              acc_r   <= {32'd0, fast_res_s};
              opb_r   <= 32'd0;
            end else if (is_div_s) begin
              state_r <= ST_CALC;
              acc_r   <= {32'd0, mag1_s};
              opb_r   <= mag2_s;
            end else begin
              state_r <= ST_CALC;
              acc_r   <= {32'd0, mag2_s};
              opb_r   <= mag1_s;
            end
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        ST_FAST: begin
          result_r <= acc_r[31:0];
          state_r  <= ST_DONE;
          done_r   <= 1'b1;
        end
        ST_CALC: begin
          acc_r <= acc_step_s;
          cnt_r <= cnt_r + 6'd1;
          if (cnt_r == 6'd31) begin
            result_r <= calc_res_s;
            state_r  <= ST_DONE;
            done_r   <= 1'b1;
          end else begin
            done_r <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu.stall_o  = ((state_r == ST_IDLE) && mdu.start_i && !mdu.flush_i) ||
                        (state_r == ST_CALC) || (state_r == ST_FAST);
  assign mdu.busy_o   = busy_r;
  assign mdu.done_o   = done_r;
  assign mdu.result_o = result_r;

endmodule
